// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda product accumulator datapath:
// FSM state encoding and default widths of the product/accumulator path.
package dadda_pkg;

    // Default product width: 2*WIDTH of the upstream 8x8 dadda_mult.
    localparam int PROD_W_DEF = 16;
    // Default accumulator width; must be >= PROD_W.
    localparam int ACC_W_DEF  = 20;
    // Default width of the frame-length input.
    localparam int LEN_W_DEF  = 8;

    // Frame FSM: waiting for a frame, summing beats, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dadda_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with the
// carry out of the top bit exposed so the caller can keep a sticky overflow.
module dadda_acc_add
    import dadda_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int PROD_W = PROD_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    // One extra bit of headroom captures the carry out of ACC_W.
    assign wide         = {1'b0, a} + (ACC_W + 1)'(b);
    assign {carry, sum} = wide;

endmodule

// File: rtl/dadda_product_accumulator.sv
// Sums a frame of LEN unsigned products into one accumulator and presents the
// frame sum plus a sticky overflow flag on a valid/ready output port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Input side: in_ready is 1 only in ACCUM and depends on state alone.
// Output side: out_valid is 1 only in DONE and depends on state alone;
// out_sum/out_ovf stay stable until out_ready. Neither ready nor valid is a
// combinational function of the opposite side's signal.
module dadda_product_accumulator
    import dadda_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t            state;
    state_t            next_state;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  len_q;
    logic              ovf;
    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;
    logic              beat;
    logic              last_beat;
    logic              take_frame;

    // A beat is consumed whenever ACCUM sees in_valid (in_ready is 1 there).
    assign beat       = (state == ACCUM) && in_valid;
    assign last_beat  = beat && (count == len_q - ONE);
    // A new frame may start from IDLE, or from DONE in the cycle the result leaves.
    assign take_frame = start && ((state == IDLE) || ((state == DONE) && out_ready));

    dadda_acc_add #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_add (
        .a     (acc),
        .b     (in_prod),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        next_state = (len == '0) ? DONE : ACCUM;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
        end
    end

    // Handshake and status outputs decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b1;
        endcase
    end

    // Frame datapath: clear on abort or new frame, accumulate on each beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (abort) begin
            acc   <= '0;
            count <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (take_frame) begin
            acc   <= '0;
            count <= '0;
            len_q <= len;
            ovf   <= 1'b0;
        end else if (beat) begin
            acc   <= add_sum;
            count <= count + ONE;
            ovf   <= ovf | add_carry;
        end
    end

    assign out_sum = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Bench for dadda_product_accumulator: table-driven frames, hand-written
// corner sequences and randomized frames against an arithmetic frame model.
module tb_dadda_product_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 20;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Scoreboard entries are {ovf, sum}.
    logic [ACC_W:0]    exp_q[$];
    logic [PROD_W-1:0] beat_q[$];

    typedef struct {
        int            n;
        int            base;
        int            step;
        logic [ACC_W-1:0] exp_sum;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[7];

    dadda_product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Frame result from plain arithmetic: the true sum wraps modulo 2^ACC_W,
    // and since every addend is non-negative some addition carried out
    // exactly when the true sum reaches 2^ACC_W.
    function automatic logic [ACC_W:0] model_frame();
        logic [63:0] total;
        total = 64'd0;
        foreach (beat_q[i]) total += 64'(beat_q[i]);
        return {(total >= (64'd1 << ACC_W)), total[ACC_W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_beats(input bit noisy);
        foreach (beat_q[i]) begin
            int gap;
            int wait_n;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                in_valid = 1'b0;
                in_prod  = PROD_W'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_prod  = beat_q[i];
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                len   = LEN_W'($urandom);
            end
            wait_n = 0;
            while (!in_ready && wait_n < 20) begin
                tick();
                wait_n++;
            end
            check("beat_in_ready", 32'(in_ready), 32'd1);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic get_result(input string name, input int hold);
        logic [ACC_W:0] exp;
        wait_valid(name);
        exp = exp_q.pop_front();
        repeat (hold) begin
            tick();
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        check({name, "_sum"}, 32'(out_sum), 32'(exp[ACC_W-1:0]));
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp[ACC_W]));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_released"}, 32'(out_valid), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input string name, input int n, input bit noisy);
        exp_q.push_back(model_frame());
        start_frame(n);
        send_beats(noisy);
        get_result(name, $urandom_range(0, 2));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{1,   7,     0,  20'd7,       1'b0};
        vecs[1] = '{17,  65025, 0,  20'd56849,   1'b1};
        vecs[2] = '{16,  65025, 0,  20'd1040400, 1'b0};
        vecs[3] = '{2,   65535, 0,  20'd131070,  1'b0};
        vecs[4] = '{4,   100,   50, 20'd700,     1'b0};
        vecs[5] = '{0,   0,     0,  20'd0,       1'b0};
        vecs[6] = '{255, 65535, 0,  20'd982785,  1'b1};

        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;

        #12;
        check("reset_in_ready",  32'(in_ready),  32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum",   32'(out_sum),   32'd0);
        check("reset_out_ovf",   32'(out_ovf),   32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Three-beat frame with exact latency.
        beat_q = {16'd20000, 16'd65025, 16'd1};
        exp_q.push_back({1'b0, 20'd85026});
        start_frame(3);
        check("t1_busy", 32'(busy), 32'd1);
        foreach (beat_q[i]) begin
            in_valid = 1'b1;
            in_prod  = beat_q[i];
            check("t1_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        get_result("t1", 0);

        // Table-driven frames.
        foreach (vecs[v]) begin
            beat_q.delete();
            for (int i = 0; i < vecs[v].n; i++) beat_q.push_back(PROD_W'(vecs[v].base + i * vecs[v].step));
            exp_q.push_back({vecs[v].exp_ovf, vecs[v].exp_sum});
            start_frame(vecs[v].n);
            send_beats(1'b0);
            get_result($sformatf("vec%0d", v), 1);
        end

        // len=0 right after a nonzero frame: result is 0 the cycle after start.
        beat_q = {16'd999};
        exp_q.push_back(model_frame());
        start_frame(1);
        send_beats(1'b0);
        get_result("pre_len0", 0);
        start_frame(0);
        check("len0_valid",    32'(out_valid), 32'd1);
        check("len0_sum",      32'(out_sum),   32'd0);
        check("len0_ovf",      32'(out_ovf),   32'd0);
        check("len0_in_ready", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("len0_idle", 32'(busy), 32'd0);

        // Backpressure: result held, start ignored while out_ready is low.
        beat_q = {16'd1234, 16'd4321, 16'd5555};
        exp_q.push_back(model_frame());
        start_frame(3);
        send_beats(1'b0);
        wait_valid("bp");
        repeat (5) begin
            start = 1'b1;
            len   = 8'd4;
            tick();
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(out_sum),   32'(exp_q[0][ACC_W-1:0]));
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        start = 1'b0;
        get_result("bp", 0);

        // Back-to-back: result taken and new frame started in the same cycle.
        beat_q = {16'd300, 16'd400};
        exp_q.push_back(model_frame());
        start_frame(2);
        send_beats(1'b0);
        wait_valid("b2b_first");
        check("b2b_first_sum", 32'(out_sum), 32'(exp_q[0][ACC_W-1:0]));
        void'(exp_q.pop_front());
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b_in_ready",  32'(in_ready),  32'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd0);
        beat_q = {16'd10, 16'd20};
        exp_q.push_back({1'b0, 20'd30});
        send_beats(1'b0);
        get_result("b2b", 0);

        // Abort after 2 of 4 beats, with start asserted alongside.
        beat_q = {16'd1000, 16'd2000};
        start_frame(4);
        send_beats(1'b0);
        abort = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy",     32'(busy),      32'd0);
        check("abort_in_ready", 32'(in_ready),  32'd0);
        repeat (3) tick();
        check("abort_no_result", 32'(out_valid), 32'd0);

        // Abort while holding a result: nothing is emitted.
        beat_q = {16'd5};
        start_frame(1);
        send_beats(1'b0);
        wait_valid("abort_done");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_done_valid", 32'(out_valid), 32'd0);
        check("abort_done_busy",  32'(busy),      32'd0);

        // Frame after aborts sums from a clean accumulator.
        beat_q = {16'd11, 16'd22, 16'd33};
        run_frame("post_abort", 3, 1'b0);

        // Asynchronous reset while an overflowed result is held.
        beat_q.delete();
        for (int i = 0; i < 17; i++) beat_q.push_back(16'd65025);
        start_frame(17);
        send_beats(1'b0);
        wait_valid("rst_pre");
        check("rst_pre_ovf", 32'(out_ovf), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-frame, then a fresh frame.
        beat_q = {16'd60000, 16'd60000};
        start_frame(4);
        send_beats(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_sum",      32'(out_sum),  32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check("rst_mid_busy",     32'(busy),     32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        beat_q = {16'd7, 16'd8, 16'd9, 16'd10};
        run_frame("post_reset", 4, 1'b0);

        // Randomized frames with stray start pulses during accumulation.
        for (int f = 0; f < 25; f++) begin
            int n;
            bit hi;
            n  = $urandom_range(0, 24);
            hi = ($urandom_range(0, 2) == 0);
            beat_q.delete();
            for (int i = 0; i < n; i++) begin
                if (hi) beat_q.push_back(PROD_W'($urandom_range(60000, 65535)));
                else    beat_q.push_back(PROD_W'($urandom_range(0, 65535)));
            end
            run_frame($sformatf("rand%0d", f), n, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
